// File: rtl/btn_pkg.sv
// Shared definitions for the push-button input path.
// Holds default parameter values, the counter-width helper and the channel state type.
// Imported by debounce_channel and button_debounce.
package btn_pkg;

  localparam int N_BTN_DEF           = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 1000;
  localparam int CNT_W_DEF           = 8;

  // Counter must be able to hold values up to DEBOUNCE_CYCLES.
  function automatic int ctr_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  // Channel state, mainly so waveforms read as IDLE/PENDING instead of raw bits.
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } chan_state_e;

endpackage

// File: rtl/debounce_channel.sv
// Purpose : one button bit -- 2-flop synchroniser, stability counter, clean level, strobes.
// Latency : a clean input step reaches btn_o 2 + DEBOUNCE_CYCLES rising edges later.
// Ports   : clk_i/rst_i (sync, active-high), btn_i raw level, btn_o debounced level,
//           press_o/release_o 1-cycle strobes aligned with the btn_o change,
//           press_nxt_o combinational preview of press_o for the shared press counter.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o,
  output logic press_nxt_o
);

  localparam int                CTR_W = ctr_width(DEBOUNCE_CYCLES);
  localparam logic [CTR_W-1:0]  LAST  = CTR_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             lvl_q;
  logic             press_q, release_q;
  logic [CTR_W-1:0] cnt_q;
  chan_state_e      state_q;
  logic             accept_w;

  // Synchroniser; s2_q is the only sample the debouncer looks at.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // cnt_q is 0 in IDLE, so with DEBOUNCE_CYCLES == 1 (LAST == 0) the very
  // first differing sample is accepted; otherwise acceptance happens on the
  // DEBOUNCE_CYCLES-th consecutive differing sample.
  assign accept_w    = (s2_q != lvl_q) && (cnt_q == LAST);
  assign press_nxt_o = accept_w && s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (accept_w) begin
        lvl_q     <= s2_q;
        press_q   <= s2_q;
        release_q <= ~s2_q;
        cnt_q     <= '0;
        state_q   <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (s2_q != lvl_q) begin
              cnt_q   <= CTR_W'(1);
              state_q <= PENDING;
            end
          end
          PENDING: begin
            if (s2_q == lvl_q) begin
              // Input fell back before it was stable long enough: glitch.
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CTR_W'(1);
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign btn_o     = lvl_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debounce.sv
// Purpose : synchronise and debounce N_BTN raw buttons; clean levels, strobes, press count.
// Latency : btn_o/press_o/release_o follow a clean step after 2 + DEBOUNCE_CYCLES edges;
//           press_count_o updates in the same cycle the press strobes are high.
// Ports   : clk_i, rst_i (sync, active-high), btn_i raw levels, btn_o debounced levels,
//           press_o/release_o per-channel strobes, press_count_o wrapping press total.
module button_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [CNT_W-1:0] press_count_o
);

  logic [N_BTN-1:0] press_nxt;
  logic [CNT_W-1:0] press_pop;
  logic [CNT_W-1:0] press_count_d, press_count_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .btn_i      (btn_i[g]),
      .btn_o      (btn_o[g]),
      .press_o    (press_o[g]),
      .release_o  (release_o[g]),
      .press_nxt_o(press_nxt[g])
    );
  end

  // Use the next-cycle press vector so the count lands together with the strobes.
  always_comb begin
    press_pop = '0;
    for (int i = 0; i < N_BTN; i++) begin
      press_pop = press_pop + CNT_W'(press_nxt[i]);
    end
    press_count_d = press_count_q + press_pop;  // wraps silently
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      press_count_q <= '0;
    end else begin
      press_count_q <= press_count_d;
    end
  end

  assign press_count_o = press_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Purpose : self-checking bench for button_debounce with a run-length reference model.
// Latency : n/a (bench).
// Ports   : none.
module tb_button_debounce;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  btn_i;
  logic [N-1:0]  btn_o, press_o, release_o;
  logic [CW-1:0] press_count_o;

  always #5 clk = ~clk;

  button_debounce #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .btn_i        (btn_i),
    .btn_o        (btn_o),
    .press_o      (press_o),
    .release_o    (release_o),
    .press_count_o(press_count_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each edge consumes the input applied two edges earlier
  // and counts how many consecutive samples disagree with the accepted level.
  logic [N-1:0]  m_lvl, m_press, m_rel;
  logic [CW-1:0] m_cnt;
  int            m_run[N];
  logic [N-1:0]  hist[$];

  task automatic model_edge(input logic r, input logic [N-1:0] b);
    logic [N-1:0] samp;
    m_press = '0;
    m_rel   = '0;
    if (r) begin
      m_lvl = '0;
      m_cnt = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
    end else begin
      samp = hist.pop_front();
      hist.push_back(b);
      for (int i = 0; i < N; i++) begin
        if (samp[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_lvl[i] = samp[i];
            if (samp[i]) m_press[i] = 1'b1;
            else         m_rel[i]   = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_cnt = m_cnt + CW'($countones(m_press));
    end
  endtask

  task automatic tick(input logic r, input logic [N-1:0] b);
    rst_i = r;
    btn_i = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check_eq("btn_o",         32'(btn_o),         32'(m_lvl));
    check_eq("press_o",       32'(press_o),       32'(m_press));
    check_eq("release_o",     32'(release_o),     32'(m_rel));
    check_eq("press_count_o", 32'(press_count_o), 32'(m_cnt));
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, '0);
  endtask

  int lat, npress, nrel, pcyc;
  logic [N-1:0] seen_btn, cur;
  int hold[N];

  initial begin
    rst_i = 1'b1;
    btn_i = '0;
    hist.push_back('0);
    hist.push_back('0);
    m_lvl = '0; m_cnt = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;

    // Reset state
    do_reset();
    check_eq("reset_btn",   32'(btn_o), 0);
    check_eq("reset_count", 32'(press_count_o), 0);

    // 1. Clean step on channel 0
    lat = -1; npress = 0;
    for (int k = 1; k <= 14; k++) begin
      tick(1'b0, 4'b0001);
      if (press_o[0]) begin lat = k; npress++; end
    end
    check_eq("t1_latency", 32'(lat), 10);
    check_eq("t1_npress",  32'(npress), 1);
    check_eq("t1_btn",     32'(btn_o), 32'h1);
    check_eq("t1_count",   32'(press_count_o), 1);

    // 2. Glitch on channel 1
    do_reset();
    seen_btn = '0; npress = 0;
    for (int k = 0; k < 25; k++) begin
      tick(1'b0, (k < 5) ? 4'b0010 : 4'b0000);
      seen_btn = seen_btn | btn_o;
      npress += $countones(press_o);
    end
    check_eq("t2_btn",    32'(seen_btn), 0);
    check_eq("t2_npress", 32'(npress), 0);
    check_eq("t2_count",  32'(press_count_o), 0);

    // 3. Bounce on channel 2, then settle high, then fall
    do_reset();
    npress = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, (((k / 3) % 2) == 0) ? 4'b0100 : 4'b0000);
      npress += $countones(press_o);
    end
    check_eq("t3_bounce_npress", 32'(npress), 0);
    lat = -1;
    for (int k = 1; k <= 14; k++) begin
      tick(1'b0, 4'b0100);
      if (press_o[2]) begin lat = k; npress++; end
    end
    check_eq("t3_press_latency", 32'(lat), 10);
    check_eq("t3_npress",        32'(npress), 1);
    lat = -1; nrel = 0;
    for (int k = 1; k <= 14; k++) begin
      tick(1'b0, 4'b0000);
      if (release_o[2]) begin lat = k; nrel++; end
    end
    check_eq("t3_release_latency", 32'(lat), 10);
    check_eq("t3_nrel",            32'(nrel), 1);

    // 4. Simultaneous press on all channels
    do_reset();
    pcyc = 0; cur = '0;
    for (int k = 1; k <= 14; k++) begin
      tick(1'b0, 4'b1111);
      if (press_o != '0) begin pcyc++; cur = press_o; end
    end
    check_eq("t4_press_vec",    32'(cur), 32'hF);
    check_eq("t4_press_cycles", 32'(pcyc), 1);
    check_eq("t4_count",        32'(press_count_o), 4);

    // 5. Wrap of the press counter
    do_reset();
    for (int p = 0; p < 257; p++) begin
      for (int k = 0; k < 11; k++) tick(1'b0, 4'b0001);
      if (p == 253) check_eq("t5_preload", 32'(press_count_o), 254);
      if (p == 254) check_eq("t5_wrap255", 32'(press_count_o), 255);
      if (p == 255) check_eq("t5_wrap0",   32'(press_count_o), 0);
      if (p == 256) check_eq("t5_wrap1",   32'(press_count_o), 1);
      for (int k = 0; k < 11; k++) tick(1'b0, 4'b0000);
    end

    // 6. Reset in the middle of a pending press, button held through it
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b0, 4'b0001);
    seen_btn = '0; npress = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 4'b0001);
      seen_btn = seen_btn | btn_o | press_o | release_o;
      npress += int'(press_count_o);
    end
    check_eq("t6_outputs_in_reset", 32'(seen_btn), 0);
    check_eq("t6_count_in_reset",   32'(npress), 0);
    lat = -1; npress = 0;
    for (int k = 1; k <= 14; k++) begin
      tick(1'b0, 4'b0001);
      if (k == 1) check_eq("t6_exit_strobe", 32'(press_o | release_o), 0);
      if (press_o[0]) begin lat = k; npress++; end
    end
    check_eq("t6_latency", 32'(lat), 10);
    check_eq("t6_npress",  32'(npress), 1);
    check_eq("t6_count",   32'(press_count_o), 1);

    // Randomised traffic: each channel holds a random level for a random time.
    do_reset();
    cur = '0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          cur[i]  = ~cur[i];
          hold[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, D) : $urandom_range(D, 3 * D);
        end
        hold[i]--;
      end
      tick(($urandom_range(0, 999) == 0), cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
